// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control strobes, instruction-memory req/ack handshake and IR/PC outputs.
// The fetch unit is the master; control and instruction memory sit on the slave side.
interface fetch_unit_if #(
    parameter int ADDR_W = 5,
    parameter int OPC_W  = 3
);
    logic                     memIns_en;
    logic                     pc_en;
    logic                     pc_load;
    logic                     halt;
    logic                     imem_req;
    logic [ADDR_W-1:0]        imem_addr;
    logic                     imem_ack;
    logic [OPC_W+ADDR_W-1:0]  imem_rdata;
    logic [OPC_W-1:0]         opcode;
    logic [ADDR_W-1:0]        operand;
    logic [ADDR_W-1:0]        pc;
    logic                     ir_valid;
    logic                     fetch_err;

    modport master (
        input  memIns_en, pc_en, pc_load, halt, imem_ack, imem_rdata,
        output imem_req, imem_addr, opcode, operand, pc, ir_valid, fetch_err
    );

    modport slave (
        output memIns_en, pc_en, pc_load, halt, imem_ack, imem_rdata,
        input  imem_req, imem_addr, opcode, operand, pc, ir_valid, fetch_err
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns PC/IR, issues one req/ack fetch at a time; IR updates on the ack edge.
// Memory may stall indefinitely up to TIMEOUT cycles, then the request is aborted and fetch_err sticks.
module fetch_unit #(
    parameter int ADDR_W  = 5,
    parameter int OPC_W   = 3,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    localparam int IW    = OPC_W + ADDR_W;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t             r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [IW-1:0]      r_ir, w_ir_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_req, w_req_nxt;
    logic               r_ir_valid, w_ir_valid_nxt;
    logic               r_err, w_err_nxt;
    logic               w_timeout_hit;

    assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CNT_MAX);

    // PC runs independently of the FSM; the outstanding address is held in r_addr.
    always_comb begin
        w_pc_nxt = r_pc;
        if (!bus.halt) begin
            if (bus.pc_load) begin
                w_pc_nxt = r_ir[ADDR_W-1:0];
            end else if (bus.pc_en) begin
                w_pc_nxt = r_pc + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_ir_nxt       = r_ir;
        w_cnt_nxt      = r_cnt;
        w_req_nxt      = r_req;
        w_ir_valid_nxt = 1'b0;
        w_err_nxt      = r_err;
        case (r_state)
            S_IDLE: begin
                w_req_nxt = 1'b0;
                if (bus.memIns_en && !bus.halt) begin
                    w_state_nxt = S_REQ;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = r_pc;
                    w_cnt_nxt   = '0;
                end
            end
            S_REQ: begin
                if (bus.imem_ack) begin
                    w_ir_nxt       = bus.imem_rdata;
                    w_req_nxt      = 1'b0;
                    w_ir_valid_nxt = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else if (w_timeout_hit) begin
                    w_req_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_addr     <= '0;
            r_ir       <= '0;
            r_cnt      <= '0;
            r_req      <= 1'b0;
            r_ir_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_addr     <= w_addr_nxt;
            r_ir       <= w_ir_nxt;
            r_cnt      <= w_cnt_nxt;
            r_req      <= w_req_nxt;
            r_ir_valid <= w_ir_valid_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign bus.imem_req  = r_req;
    assign bus.imem_addr = r_addr;
    assign bus.opcode    = r_ir[IW-1:ADDR_W];
    assign bus.operand   = r_ir[ADDR_W-1:0];
    assign bus.pc        = r_pc;
    assign bus.ir_valid  = r_ir_valid;
    assign bus.fetch_err = r_err;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, zero-wait and stalled fetches, PC priority, wrap, timeout, async reset.
module tb_fetch_unit;
    localparam int ADDR_W  = 5;
    localparam int OPC_W   = 3;
    localparam int TIMEOUT = 15;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    fetch_unit_if #(.ADDR_W(ADDR_W), .OPC_W(OPC_W)) bus ();

    fetch_unit #(.ADDR_W(ADDR_W), .OPC_W(OPC_W), .TIMEOUT(TIMEOUT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst            = 1'b1;
        bus.memIns_en  = 1'b0;
        bus.pc_en      = 1'b0;
        bus.pc_load    = 1'b0;
        bus.halt       = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;

        tick();
        tick();
        chk("rst_pc",       32'(bus.pc),        32'd0);
        chk("rst_opcode",   32'(bus.opcode),    32'd0);
        chk("rst_req",      32'(bus.imem_req),  32'd0);
        chk("rst_err",      32'(bus.fetch_err), 32'd0);
        chk("rst_irv",      32'(bus.ir_valid),  32'd0);
        rst = 1'b0;

        // zero-wait fetch of 101_00011
        bus.memIns_en = 1'b1;
        tick();
        chk("zw_req",  32'(bus.imem_req),  32'd1);
        chk("zw_addr", 32'(bus.imem_addr), 32'd0);
        bus.memIns_en  = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 8'b101_00011;
        tick();
        chk("zw_opcode",  32'(bus.opcode),   32'd5);
        chk("zw_operand", 32'(bus.operand),  32'd3);
        chk("zw_irv1",    32'(bus.ir_valid), 32'd1);
        chk("zw_req_off", 32'(bus.imem_req), 32'd0);
        bus.imem_ack = 1'b0;
        tick();
        chk("zw_irv0", 32'(bus.ir_valid), 32'd0);

        // ack while idle must be ignored
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 8'b111_11111;
        tick();
        chk("idle_ack_opc", 32'(bus.opcode),   32'd5);
        chk("idle_ack_irv", 32'(bus.ir_valid), 32'd0);
        bus.imem_ack = 1'b0;

        // stalled fetch with a PC increment during REQ
        bus.memIns_en = 1'b1;
        tick();
        chk("ws_req",  32'(bus.imem_req),  32'd1);
        chk("ws_addr", 32'(bus.imem_addr), 32'd0);
        bus.memIns_en = 1'b0;
        bus.pc_en     = 1'b1;
        tick();
        chk("ws_pc1",     32'(bus.pc),        32'd1);
        chk("ws_addr_hold", 32'(bus.imem_addr), 32'd0);
        chk("ws_req_hold",  32'(bus.imem_req),  32'd1);
        bus.pc_en = 1'b0;
        tick();
        chk("ws_irv_wait", 32'(bus.ir_valid), 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 8'b011_10100;
        tick();
        chk("ws_opcode",  32'(bus.opcode),   32'd3);
        chk("ws_operand", 32'(bus.operand),  32'd20);
        chk("ws_irv",     32'(bus.ir_valid), 32'd1);
        chk("ws_req_off", 32'(bus.imem_req), 32'd0);
        chk("ws_pc_keep", 32'(bus.pc),       32'd1);
        bus.imem_ack = 1'b0;

        // pc_load beats pc_en
        bus.pc_load = 1'b1;
        bus.pc_en   = 1'b1;
        tick();
        chk("jmp_pc", 32'(bus.pc), 32'd20);
        bus.pc_load   = 1'b0;
        bus.halt      = 1'b1;
        bus.memIns_en = 1'b1;
        tick();
        chk("halt_pc",  32'(bus.pc),       32'd20);
        chk("halt_req", 32'(bus.imem_req), 32'd0);
        tick();
        chk("halt_pc2",  32'(bus.pc),       32'd20);
        chk("halt_req2", 32'(bus.imem_req), 32'd0);
        bus.halt      = 1'b0;
        bus.pc_en     = 1'b0;
        bus.memIns_en = 1'b0;
        tick();

        // fetch operand 31, jump there, then wrap
        bus.memIns_en = 1'b1;
        tick();
        chk("wr_addr", 32'(bus.imem_addr), 32'd20);
        bus.memIns_en  = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 8'b000_11111;
        tick();
        chk("wr_operand", 32'(bus.operand), 32'd31);
        bus.imem_ack = 1'b0;
        bus.pc_load  = 1'b1;
        tick();
        chk("wr_pc31", 32'(bus.pc), 32'd31);
        bus.pc_load = 1'b0;
        bus.pc_en   = 1'b1;
        tick();
        chk("wr_pc0", 32'(bus.pc), 32'd0);
        bus.pc_en = 1'b0;

        // timeout: no ack for TIMEOUT REQ cycles
        bus.memIns_en = 1'b1;
        tick();
        chk("to_req", 32'(bus.imem_req), 32'd1);
        bus.memIns_en = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("to_req_last", 32'(bus.imem_req),  32'd1);
        chk("to_err_pre",  32'(bus.fetch_err), 32'd0);
        tick();
        chk("to_req_drop", 32'(bus.imem_req),  32'd0);
        chk("to_err",      32'(bus.fetch_err), 32'd1);
        chk("to_ir_keep",  32'({bus.opcode, bus.operand}), 32'h1F);
        chk("to_irv",      32'(bus.ir_valid),  32'd0);

        // fetch after error still works, error stays set
        bus.memIns_en = 1'b1;
        tick();
        chk("pe_req",  32'(bus.imem_req),  32'd1);
        chk("pe_addr", 32'(bus.imem_addr), 32'd0);
        bus.memIns_en  = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 8'b110_00101;
        tick();
        chk("pe_opcode",  32'(bus.opcode),    32'd6);
        chk("pe_operand", 32'(bus.operand),   32'd5);
        chk("pe_irv",     32'(bus.ir_valid),  32'd1);
        chk("pe_err",     32'(bus.fetch_err), 32'd1);

        // level-sensitive re-request: REQ, ack->IDLE, REQ again
        bus.memIns_en = 1'b1;
        tick();
        chk("lv_req1", 32'(bus.imem_req), 32'd1);
        tick();
        chk("lv_idle", 32'(bus.imem_req), 32'd0);
        chk("lv_irv",  32'(bus.ir_valid), 32'd1);
        tick();
        chk("lv_req2", 32'(bus.imem_req), 32'd1);

        // asynchronous reset mid-REQ, well before the next edge
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req",    32'(bus.imem_req),  32'd0);
        chk("arst_opcode", 32'(bus.opcode),    32'd0);
        chk("arst_err",    32'(bus.fetch_err), 32'd0);
        chk("arst_irv",    32'(bus.ir_valid),  32'd0);
        bus.memIns_en = 1'b0;
        bus.imem_ack  = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_req", 32'(bus.imem_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
